// File: rtl/float_multiplier_stream_if.sv
// Stream bundle for the binary32 multiplier: two operand ports and one result port,
// each with a stb/ack handshake.
interface float_multiplier_stream_if;
    logic [31:0] input_a;
    logic        input_a_stb;
    logic        input_a_ack;
    logic [31:0] input_b;
    logic        input_b_stb;
    logic        input_b_ack;
    logic [31:0] output_z;
    logic        output_z_stb;
    logic        output_z_ack;

    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb
    );

    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb
    );
endinterface

// File: rtl/float_multiplier_stream.sv
// Multi-cycle IEEE-754 binary32 multiplier, one operation in flight, flush-to-zero
// on subnormal inputs and underflow, round to nearest even.
module float_multiplier_stream (
    input logic                      clk,
    input logic                      rst,
    float_multiplier_stream_if.slave s
);
    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, state_n;

    logic              a_ack, b_ack, z_stb;
    logic [31:0]       a, b, z;
    logic              a_s, b_s, sign;
    logic [7:0]        a_e, b_e;
    logic [23:0]       a_m, b_m, mant;
    logic signed [9:0] e;
    logic [47:0]       prod;
    logic              guard, rnd, sticky;

    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        special_hit;
    logic [31:0] special_z;

    assign s.input_a_ack  = a_ack;
    assign s.input_b_ack  = b_ack;
    assign s.output_z_stb = z_stb;
    assign s.output_z     = z;

    assign a_nan  = (a_e == 8'hFF) && (a_m[22:0] != 23'd0);
    assign b_nan  = (b_e == 8'hFF) && (b_m[22:0] != 23'd0);
    assign a_inf  = (a_e == 8'hFF) && (a_m[22:0] == 23'd0);
    assign b_inf  = (b_e == 8'hFF) && (b_m[22:0] == 23'd0);
    assign a_zero = (a_e == 8'd0);
    assign b_zero = (b_e == 8'd0);

    always_comb begin
        special_hit = 1'b1;
        special_z   = 32'h7FC00000;
        if (a_nan || b_nan)
            special_z = 32'h7FC00000;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            special_z = 32'h7FC00000;
        else if (a_inf || b_inf)
            special_z = {a_s ^ b_s, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
            special_z = {a_s ^ b_s, 31'd0};
        else
            special_hit = 1'b0;
    end

    always_comb begin
        state_n = state;
        case (state)
            GET_A:     if (a_ack && s.input_a_stb) state_n = GET_B;
            GET_B:     if (b_ack && s.input_b_stb) state_n = UNPACK;
            UNPACK:    state_n = SPECIAL;
            SPECIAL:   state_n = special_hit ? PUT_Z : MULTIPLY;
            MULTIPLY:  state_n = NORMALISE;
            NORMALISE: state_n = ROUND;
            ROUND:     state_n = PACK;
            PACK:      state_n = PUT_Z;
            PUT_Z:     if (z_stb && s.output_z_ack) state_n = GET_A;
            default:   state_n = GET_A;
        endcase
    end

    // Acks rise one edge after entering the wait state and fall on the edge after a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GET_A;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            z_stb <= 1'b0;
        end else begin
            state <= state_n;
            a_ack <= (state == GET_A) && (state_n == GET_A);
            b_ack <= (state == GET_B) && (state_n == GET_B);
            z_stb <= (state_n == PUT_Z);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z <= 32'd0;
        end else begin
            case (state)
                GET_A: if (a_ack && s.input_a_stb) a <= s.input_a;
                GET_B: if (b_ack && s.input_b_stb) b <= s.input_b;
                UNPACK: begin
                    a_s <= a[31];
                    b_s <= b[31];
                    a_e <= a[30:23];
                    b_e <= b[30:23];
                    a_m <= {1'b1, a[22:0]};
                    b_m <= {1'b1, b[22:0]};
                end
                SPECIAL: if (special_hit) z <= special_z;
                MULTIPLY: begin
                    prod <= {24'd0, a_m} * {24'd0, b_m};
                    e    <= $signed({2'b00, a_e}) + $signed({2'b00, b_e}) - 10'sd127;
                    sign <= a_s ^ b_s;
                end
                NORMALISE: begin
                    if (prod[47]) begin
                        mant   <= prod[47:24];
                        guard  <= prod[23];
                        rnd    <= prod[22];
                        sticky <= |prod[21:0];
                        e      <= e + 10'sd1;
                    end else begin
                        mant   <= prod[46:23];
                        guard  <= prod[22];
                        rnd    <= prod[21];
                        sticky <= |prod[20:0];
                    end
                end
                ROUND: begin
                    if (guard && (rnd || sticky || mant[0])) begin
                        if (mant == 24'hFFFFFF) begin
                            mant <= 24'h800000;
                            e    <= e + 10'sd1;
                        end else begin
                            mant <= mant + 24'd1;
                        end
                    end
                end
                PACK: begin
                    if (e >= 10'sd255)
                        z <= {sign, 8'hFF, 23'd0};
                    else if (e <= 10'sd0)
                        z <= {sign, 31'd0};
                    else
                        z <= {sign, e[7:0], mant[22:0]};
                end
                default: ;
            endcase
        end
    end
endmodule
